sdf_rr_acc: RTL and testbench
=============================

# sdf_rr_acc

Multi-flux synchronous-dataflow accumulating actor. It is the parametrised successor of the single-mode sdf actor. Each firing consumes one token from every input port of one flux and folds them into that flux's accumulator with a selectable operator (sum/max/min). After NUM_OP firings the result is emitted: either every partial result or only the final one. Fluxes are served round-robin, and the output is registered. It sits between a read FIFO bank and a write FIFO in the multi_dataflow actor network.

## Interface
- DATA_WIDTH, 8: token data width, unsigned.
- FLUX, 2: number of independent tagged fluxes (≥1).
- PORTS, 2: input ports per flux (≥1).
- NUM_OP, 4: firings per result (≥1). Elaboration fails on 0.
- OP, OP_SUM: OP_SUM / OP_MAX / OP_MIN.
- EMIT, EMIT_ALL: EMIT_ALL writes every partial result; EMIT_LAST writes only the final one.
- SAT, 1: OP_SUM only. 1 clamps the output to 2^DATA_WIDTH-1; 0 truncates it.
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- read_port.empty  in  PORTS*FLUX  lane l = p+f*PORTS.
- read_port.dout  in  PORTS*FLUX*DATA_WIDTH  lane l occupies bits [(l+1)*DATA_WIDTH-1 : l*DATA_WIDTH].
- read_port.read  out  PORTS*FLUX  one-cycle pop per lane.
- write_port.full  in  1  downstream FIFO full.
- write_port.write  out  1  push.
- write_port.din  out  TAG_WIDTH+DATA_WIDTH  {tag, data}; TAG_WIDTH = max(1, $clog2(FLUX)).

## Operation
- Per flux state:
  - cnt[f], width max(1, $clog2(NUM_OP)), reset to NUM_OP-1.
  - acc[f], width ACC_W = DATA_WIDTH + $clog2(PORTS*NUM_OP) + 1, reset to INIT.
  - INIT is 0 for SUM and MAX, and all-ones for MIN.
- Output register out_valid/out_tag/out_data; out_valid resets to 0.
- Flux f is ready when every empty[p+f*PORTS] = 0.
- final(f) is true when cnt[f] = 0.
- slot_ok = !out_valid | !write_port.full.
- Flux f is eligible when it is ready and one of the following holds:
  - slot_ok;
  - EMIT = EMIT_LAST and !final(f). Non-emitting firings need no output slot.
- Arbitration:
  - Grant the first eligible flux scanning ptr, ptr+1, …, wrapping mod FLUX.
  - ptr resets to 0; after each firing it becomes grant+1 mod FLUX.
- Firing flux g:
  - Assert read for all PORTS lanes of g; all other read bits are 0.
  - step = sum of the lanes (SUM), the max lane (MAX) or the min lane (MIN), zero-extended to ACC_W.
  - nxt = acc+step (SUM), max(acc,step) (MAX) or min(acc,step) (MIN).
- Emission happens if EMIT_ALL, or if EMIT_LAST and final(g):
  - out_data = nxt, saturated or truncated per SAT; MAX/MIN never exceed the range.
  - out_tag = g; out_valid = 1.
- Counter update: if final(g), acc[g] ← INIT and cnt[g] ← NUM_OP-1; otherwise acc[g] ← nxt and cnt[g] ← cnt[g]-1.
- write_port.write = out_valid & !full.
- write_port.din = {out_tag, out_data}, held stable while out_valid and full.
- If the register is drained and nothing new is emitted in the same cycle, out_valid ← 0.
- Reset mid-operation: all acc/cnt, ptr and out_valid return to reset values next edge. Pending partial results are discarded and no write occurs in the cycle after reset.

## Timing
- Reads are combinational from empty, full, out_valid and state in the firing cycle t.
- acc/cnt/ptr/out register update at the edge ending t; write is asserted in t+1 when not full. Latency is 1 cycle.
- Throughput is one firing per cycle across fluxes while the downstream is not full. Simultaneous drain and load of the output register is allowed.
- full held high with out_valid = 1 blocks all emitting firings. Reads stay 0 except non-final EMIT_LAST firings.
- FLUX = 1: the arbiter degenerates and the tag is a constant 0.

## Structure
- Package sdf_pkg holds:
  - op_e {OP_SUM, OP_MAX, OP_MIN};
  - emit_e {EMIT_ALL, EMIT_LAST};
  - function clog2_min1.
- Sub-module rr_arbiter #(N): inputs req[N] and an advance strobe; outputs a one-hot grant, the grant index and the pointer register.
- Everything else stays in sdf_rr_acc.

## Test plan
- FLUX=2, PORTS=2, NUM_OP=4, SUM, EMIT_ALL; flux0 lanes constant 1,2 → din {0,3},{0,6},{0,9},{0,12}, then {0,3}; read[1:0]=11 each firing.
- Same setup with EMIT_LAST → exactly one write per 4 firings, din {0,12}; firings continue while full=1 until final.
- Both fluxes always ready, full=0 → grants 0,1,0,1…; din tags alternate; one write per cycle after the first.
- out_valid with full held high for 5 cycles → read=0 and din stable; release full → write the same cycle, next firing that cycle.
- DATA_WIDTH=8, lanes 200,200, NUM_OP=1 → din data 255 with SAT=1, 144 with SAT=0; OP_MIN lanes 7,3 → 3; OP_MAX → 7.
- rst after 2 of 4 firings (acc=6) → write=0 next cycle; next firing emits 3 with cnt reloaded to 3.

Source files
------------

// File: rtl/sdf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : sdf_pkg                                                        |
// | Purpose : Shared types and helpers for the synchronous-dataflow actors.  |
// |           op_e selects the folding operator, emit_e selects whether      |
// |           every partial result or only the final one is written out.     |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sdf_pkg;

  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_MAX = 2'd1,
    OP_MIN = 2'd2
  } op_e;

  typedef enum logic {
    EMIT_ALL  = 1'b0,
    EMIT_LAST = 1'b1
  } emit_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                     |
// | Purpose : Round-robin arbiter. Grants the first requester found scanning |
// |           ptr, ptr+1, ... (mod N); on advance the pointer moves to the   |
// |           slot after the current grant.                                  |
// | Ports   : clk, rst      clock / synchronous active-high reset            |
// |           req[N]        request vector                                   |
// |           advance       grant was consumed this cycle                    |
// |           grant[N]      one-hot grant (all zero when no request)         |
// |           grant_idx     binary index of the grant                        |
// |           ptr           current priority pointer                         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import sdf_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req,
  input  logic                       advance,
  output logic [N-1:0]               grant,
  output logic [clog2_min1(N)-1:0]   grant_idx,
  output logic [clog2_min1(N)-1:0]   ptr
);

  localparam int c_iw = clog2_min1(N);

  logic [c_iw-1:0] r_ptr;
  logic [c_iw-1:0] w_idx;
  logic            w_found;
  logic [2*N-1:0]  w_req2;
  logic [c_iw:0]   w_sum;

  // Rotating a doubled request vector puts requester ptr+i at bit i, so the
  // scan below only uses constant bit positions.
  assign w_req2 = {req, req} >> r_ptr;

  always_comb begin
    w_idx   = r_ptr;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_req2[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (c_iw + 1)'(i);
        if (w_sum >= (c_iw + 1)'(N)) begin
          w_sum = w_sum - (c_iw + 1)'(N);
        end
        w_idx = w_sum[c_iw-1:0];
      end
    end
  end

  assign grant     = w_found ? (N'(1) << w_idx) : '0;
  assign grant_idx = w_idx;
  assign ptr       = r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (w_idx == c_iw'(N - 1)) ? '0 : w_idx + c_iw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdf_rr_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sdf_rr_acc                                                     |
// | Purpose : Multi-flux SDF accumulating actor. Each firing pops one token  |
// |           from every port of one flux and folds them (sum/max/min) into  |
// |           that flux's accumulator; after NUM_OP firings the result is    |
// |           complete. Fluxes are served round-robin; output is registered. |
// | Ports   : clk, rst           clock / synchronous active-high reset       |
// |           read_port_empty    per-lane FIFO empty, lane = p + f*PORTS     |
// |           read_port_dout     per-lane token data                         |
// |           read_port_read     per-lane one-cycle pop                      |
// |           write_port_full    downstream FIFO full                        |
// |           write_port_write   downstream push                             |
// |           write_port_din     {tag, data}                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sdf_rr_acc
  import sdf_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    FLUX       = 2,
  parameter int    PORTS      = 2,
  parameter int    NUM_OP     = 4,
  parameter op_e   OP         = OP_SUM,
  parameter emit_e EMIT       = EMIT_ALL,
  parameter bit    SAT        = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PORTS*FLUX-1:0]                  read_port_empty,
  input  logic [PORTS*FLUX*DATA_WIDTH-1:0]       read_port_dout,
  output logic [PORTS*FLUX-1:0]                  read_port_read,
  input  logic                                   write_port_full,
  output logic                                   write_port_write,
  output logic [clog2_min1(FLUX)+DATA_WIDTH-1:0] write_port_din
);

  localparam int c_tag_w = clog2_min1(FLUX);
  localparam int c_cnt_w = clog2_min1(NUM_OP);
  localparam int c_acc_w = DATA_WIDTH + $clog2(PORTS * NUM_OP) + 1;

  localparam logic [c_acc_w-1:0] c_init =
    (OP == OP_MIN) ? {c_acc_w{1'b1}} : {c_acc_w{1'b0}};
  localparam logic [c_acc_w-1:0] c_dmax =
    {{(c_acc_w - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic [c_cnt_w-1:0] c_cnt_rst = c_cnt_w'(NUM_OP - 1);

  generate
    if (NUM_OP < 1) begin : g_bad_num_op
      $error("sdf_rr_acc: NUM_OP must be at least 1");
    end
  endgenerate

  // Per-flux state and output register
  logic [c_acc_w-1:0]    r_acc [FLUX];
  logic [c_cnt_w-1:0]    r_cnt [FLUX];
  logic                  r_out_valid;
  logic [c_tag_w-1:0]    r_out_tag;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_slot_ok;
  logic [FLUX-1:0]       w_ready;
  logic [FLUX-1:0]       w_final;
  logic [FLUX-1:0]       w_eligible;
  logic [FLUX-1:0]       w_grant_oh;
  logic [c_tag_w-1:0]    w_gidx;
  logic [c_tag_w-1:0]    w_ptr;
  logic                  w_fire;
  logic                  w_emit;
  logic                  w_final_g;
  logic [c_acc_w-1:0]    w_acc_sel;
  logic [c_acc_w-1:0]    w_lane;
  logic [c_acc_w-1:0]    w_step;
  logic [c_acc_w-1:0]    w_nxt;
  logic [DATA_WIDTH-1:0] w_out_next;

  assign w_slot_ok = !r_out_valid || !write_port_full;

  generate
    for (genvar f = 0; f < FLUX; f++) begin : g_flux
      assign w_ready[f] = ~|read_port_empty[f*PORTS +: PORTS];
      assign w_final[f] = (r_cnt[f] == '0);
      // Non-final EMIT_LAST firings write nothing, so they may proceed even
      // while the output register is stalled. Nothing fires during reset.
      assign w_eligible[f] = w_ready[f] && !rst &&
                             (w_slot_ok || (EMIT == EMIT_LAST && !w_final[f]));
      assign read_port_read[f*PORTS +: PORTS] = {PORTS{w_fire && w_grant_oh[f]}};
    end
  endgenerate

  assign w_fire = |w_eligible;

  rr_arbiter #(
    .N (FLUX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (w_eligible),
    .advance   (w_fire),
    .grant     (w_grant_oh),
    .grant_idx (w_gidx),
    .ptr       (w_ptr)
  );

  // Operand selection and folding for the granted flux.
  always_comb begin
    w_acc_sel = c_init;
    w_final_g = 1'b0;
    w_lane    = '0;
    w_step    = (OP == OP_MIN) ? c_dmax : '0;
    for (int f = 0; f < FLUX; f++) begin
      if (w_grant_oh[f]) begin
        w_acc_sel = r_acc[f];
        w_final_g = w_final[f];
        for (int p = 0; p < PORTS; p++) begin
          w_lane = c_acc_w'(read_port_dout[(f*PORTS + p)*DATA_WIDTH +: DATA_WIDTH]);
          case (OP)
            OP_MAX:  if (w_lane > w_step) w_step = w_lane;
            OP_MIN:  if (w_lane < w_step) w_step = w_lane;
            default: w_step = w_step + w_lane;
          endcase
        end
      end
    end

    case (OP)
      OP_MAX:  w_nxt = (w_step > w_acc_sel) ? w_step : w_acc_sel;
      OP_MIN:  w_nxt = (w_step < w_acc_sel) ? w_step : w_acc_sel;
      default: w_nxt = w_acc_sel + w_step;
    endcase

    // Only a sum can leave the token range; max/min results always fit.
    if (OP == OP_SUM && SAT && (w_nxt > c_dmax)) begin
      w_out_next = {DATA_WIDTH{1'b1}};
    end else begin
      w_out_next = w_nxt[DATA_WIDTH-1:0];
    end
  end

  assign w_emit = w_fire && (EMIT == EMIT_ALL || w_final_g);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        r_acc[f] <= c_init;
        r_cnt[f] <= c_cnt_rst;
      end
    end else if (w_fire) begin
      for (int f = 0; f < FLUX; f++) begin
        if (w_grant_oh[f]) begin
          if (w_final[f]) begin
            r_acc[f] <= c_init;
            r_cnt[f] <= c_cnt_rst;
          end else begin
            r_acc[f] <= w_nxt;
            r_cnt[f] <= r_cnt[f] - c_cnt_w'(1);
          end
        end
      end
    end
  end

  // A new emission may load the register in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_tag   <= w_gidx;
      r_out_data  <= w_out_next;
    end else if (write_port_write) begin
      r_out_valid <= 1'b0;
    end
  end

  assign write_port_write = r_out_valid && !write_port_full && !rst;
  assign write_port_din   = {r_out_tag, r_out_data};

endmodule
`default_nettype wire

// File: tb/tb_sdf_rr_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sdf_rr_acc                                                  |
// | Purpose : Self-checking bench for sdf_rr_acc. Expected writes are queued |
// |           when a firing is driven and compared when the DUT pushes.      |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sdf_rr_acc;
  import sdf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main DUT: FLUX=2 PORTS=2 NUM_OP=4 SUM EMIT_ALL SAT=1
  logic [3:0]  m_empty = '1;
  logic [31:0] m_dout  = '0;
  logic [3:0]  m_read;
  logic        m_full  = 1'b0;
  logic        m_write;
  logic [8:0]  m_din;

  sdf_rr_acc #(
    .DATA_WIDTH(8), .FLUX(2), .PORTS(2), .NUM_OP(4),
    .OP(OP_SUM), .EMIT(EMIT_ALL), .SAT(1'b1)
  ) u_main (
    .clk(clk), .rst(rst),
    .read_port_empty(m_empty), .read_port_dout(m_dout), .read_port_read(m_read),
    .write_port_full(m_full), .write_port_write(m_write), .write_port_din(m_din)
  );

  // EMIT_LAST DUT
  logic [3:0]  l_empty = '1;
  logic [31:0] l_dout  = '0;
  logic [3:0]  l_read;
  logic        l_full  = 1'b0;
  logic        l_write;
  logic [8:0]  l_din;

  sdf_rr_acc #(
    .DATA_WIDTH(8), .FLUX(2), .PORTS(2), .NUM_OP(4),
    .OP(OP_SUM), .EMIT(EMIT_LAST), .SAT(1'b1)
  ) u_last (
    .clk(clk), .rst(rst),
    .read_port_empty(l_empty), .read_port_dout(l_dout), .read_port_read(l_read),
    .write_port_full(l_full), .write_port_write(l_write), .write_port_din(l_din)
  );

  // Single-flux, single-firing DUTs sharing one stimulus
  logic [1:0]  s_empty = '1;
  logic [15:0] s_dout  = '0;
  logic        s_full  = 1'b0;
  logic [1:0]  s1_read, s0_read, mn_read, mx_read;
  logic        s1_write, s0_write, mn_write, mx_write;
  logic [8:0]  s1_din, s0_din, mn_din, mx_din;

  sdf_rr_acc #(.DATA_WIDTH(8), .FLUX(1), .PORTS(2), .NUM_OP(1),
               .OP(OP_SUM), .EMIT(EMIT_ALL), .SAT(1'b1)) u_sat1 (
    .clk(clk), .rst(rst), .read_port_empty(s_empty), .read_port_dout(s_dout),
    .read_port_read(s1_read), .write_port_full(s_full),
    .write_port_write(s1_write), .write_port_din(s1_din));

  sdf_rr_acc #(.DATA_WIDTH(8), .FLUX(1), .PORTS(2), .NUM_OP(1),
               .OP(OP_SUM), .EMIT(EMIT_ALL), .SAT(1'b0)) u_sat0 (
    .clk(clk), .rst(rst), .read_port_empty(s_empty), .read_port_dout(s_dout),
    .read_port_read(s0_read), .write_port_full(s_full),
    .write_port_write(s0_write), .write_port_din(s0_din));

  sdf_rr_acc #(.DATA_WIDTH(8), .FLUX(1), .PORTS(2), .NUM_OP(1),
               .OP(OP_MIN), .EMIT(EMIT_ALL), .SAT(1'b1)) u_min (
    .clk(clk), .rst(rst), .read_port_empty(s_empty), .read_port_dout(s_dout),
    .read_port_read(mn_read), .write_port_full(s_full),
    .write_port_write(mn_write), .write_port_din(mn_din));

  sdf_rr_acc #(.DATA_WIDTH(8), .FLUX(1), .PORTS(2), .NUM_OP(1),
               .OP(OP_MAX), .EMIT(EMIT_ALL), .SAT(1'b1)) u_max (
    .clk(clk), .rst(rst), .read_port_empty(s_empty), .read_port_dout(s_dout),
    .read_port_read(mx_read), .write_port_full(s_full),
    .write_port_write(mx_write), .write_port_din(mx_din));

  // Scoreboards
  logic [8:0] m_q[$];
  logic [8:0] l_q[$];

  always @(negedge clk) begin
    if (!rst && m_write) begin
      if (m_q.size() == 0) check_value("m_unexpected_write", 32'(m_write), 32'd0);
      else                 check_value("m_din", 32'(m_din), 32'(m_q.pop_front()));
    end
    if (!rst && l_write) begin
      if (l_q.size() == 0) check_value("l_unexpected_write", 32'(l_write), 32'd0);
      else                 check_value("l_din", 32'(l_din), 32'(l_q.pop_front()));
    end
  end

  task automatic reset_all();
    tick();
    rst     = 1'b1;
    m_empty = '1;
    l_empty = '1;
    s_empty = '1;
    m_full  = 1'b0;
    l_full  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_q.delete();
    l_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_value("rst_m_write", 32'(m_write), 32'd0);
    check_value("rst_m_read",  32'(m_read),  32'd0);
    check_value("rst_l_write", 32'(l_write), 32'd0);
    check_value("rst_s_write", 32'(s1_write), 32'd0);

    // Flux0 lanes 1,2, EMIT_ALL running sums, wrap after 4 firings
    tick();
    m_empty = 4'b1100;
    m_dout  = {8'd0, 8'd0, 8'd2, 8'd1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_value("t1_read", 32'(m_read), 32'b0011);
      m_q.push_back({1'b0, 8'(3 * ((i % 4) + 1))});
      tick();
    end
    m_empty = '1;
    repeat (3) @(negedge clk);
    check_value("t1_drain", 32'(m_q.size()), 32'd0);

    // Both fluxes ready: grants alternate, one write per cycle after the first
    reset_all();
    tick();
    m_empty = 4'b0000;
    m_dout  = {8'd20, 8'd10, 8'd2, 8'd1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_value("t3_read", 32'(m_read), (i % 2 == 1) ? 32'b1100 : 32'b0011);
      if (i > 0) check_value("t3_write", 32'(m_write), 32'd1);
      m_q.push_back((i % 2 == 1) ? {1'b1, 8'(30 * (i / 2 + 1))}
                                 : {1'b0, 8'(3 * (i / 2 + 1))});
      tick();
    end
    m_empty = '1;
    repeat (3) @(negedge clk);
    check_value("t3_drain", 32'(m_q.size()), 32'd0);

    // Full stall with a pending result, then release
    reset_all();
    tick();
    m_empty = 4'b1100;
    m_dout  = {8'd0, 8'd0, 8'd2, 8'd1};
    @(negedge clk);
    check_value("t4_first_read", 32'(m_read), 32'b0011);
    m_q.push_back({1'b0, 8'd3});
    tick();
    m_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_value("t4_stall_read",  32'(m_read),  32'd0);
      check_value("t4_stall_write", 32'(m_write), 32'd0);
      check_value("t4_stall_din",   32'(m_din),   32'({1'b0, 8'd3}));
      tick();
    end
    m_full = 1'b0;
    @(negedge clk);
    check_value("t4_release_write", 32'(m_write), 32'd1);
    check_value("t4_release_read",  32'(m_read),  32'b0011);
    m_q.push_back({1'b0, 8'd6});
    tick();
    m_empty = '1;
    repeat (3) @(negedge clk);
    check_value("t4_drain", 32'(m_q.size()), 32'd0);

    // EMIT_LAST: one write per 4 firings; non-final firings continue under full
    reset_all();
    tick();
    l_empty = 4'b1100;
    l_dout  = {8'd0, 8'd0, 8'd2, 8'd1};
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) l_full = 1'b1;
      @(negedge clk);
      check_value("t5_write", 32'(l_write), 32'd0);
      check_value("t5_read",  32'(l_read), (c <= 7) ? 32'b0011 : 32'd0);
      if (c == 4) l_q.push_back({1'b0, 8'd12});
      if (c >= 5) check_value("t5_din_hold", 32'(l_din), 32'({1'b0, 8'd12}));
      tick();
    end
    l_full = 1'b0;
    @(negedge clk);
    check_value("t5_release_write", 32'(l_write), 32'd1);
    check_value("t5_release_read",  32'(l_read),  32'b0011);
    l_q.push_back({1'b0, 8'd12});
    tick();
    l_empty = '1;
    repeat (3) @(negedge clk);
    check_value("t5_drain", 32'(l_q.size()), 32'd0);

    // Reset after two firings discards the partial result
    reset_all();
    tick();
    m_empty = 4'b1100;
    m_dout  = {8'd0, 8'd0, 8'd2, 8'd1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_value("t6_pre_read", 32'(m_read), 32'b0011);
      m_q.push_back({1'b0, 8'(3 * (i + 1))});
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check_value("t6_write_after_rst", 32'(m_write), 32'd0);
      check_value("t6_read", 32'(m_read), 32'b0011);
      m_q.push_back({1'b0, 8'(3 * ((i % 4) + 1))});
      tick();
    end
    m_empty = '1;
    repeat (3) @(negedge clk);
    check_value("t6_drain", 32'(m_q.size()), 32'd0);

    // Saturation / truncation / min / max on single-flux, NUM_OP=1 instances
    reset_all();
    tick();
    s_empty = 2'b00;
    s_dout  = {8'd200, 8'd200};
    @(negedge clk);
    check_value("t7_read", 32'(s1_read), 32'b11);
    tick();
    s_dout = {8'd3, 8'd7};
    @(negedge clk);
    check_value("t7_sat1_write", 32'(s1_write), 32'd1);
    check_value("t7_sat1_400", 32'(s1_din), 32'({1'b0, 8'd255}));
    check_value("t7_sat0_400", 32'(s0_din), 32'({1'b0, 8'd144}));
    check_value("t7_min_200",  32'(mn_din), 32'({1'b0, 8'd200}));
    check_value("t7_max_200",  32'(mx_din), 32'({1'b0, 8'd200}));
    tick();
    s_empty = 2'b11;
    @(negedge clk);
    check_value("t7_sat1_10", 32'(s1_din), 32'({1'b0, 8'd10}));
    check_value("t7_sat0_10", 32'(s0_din), 32'({1'b0, 8'd10}));
    check_value("t7_min_7_3", 32'(mn_din), 32'({1'b0, 8'd3}));
    check_value("t7_max_7_3", 32'(mx_din), 32'({1'b0, 8'd7}));
    check_value("t7_max_write", 32'(mx_write), 32'd1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
